// File: rtl/avalon_mem_pkg.sv
// avalon_mem_pkg: shared types and constants for the Avalon-MM slave RAM
package avalon_mem_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int AVALON_WORD_BYTES = 4;
endpackage

// File: rtl/avalon_slave_ram_if.sv
// avalon_slave_ram_if: Avalon-MM bus between CPU master and slave RAM
interface avalon_slave_ram_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;
  modport master (output read, write, address, byteenable, writedata, input waitrequest, readdata, err);
  modport slave  (input read, write, address, byteenable, writedata, output waitrequest, readdata, err);
endinterface

// File: rtl/avalon_slave_ram_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module lfsr8
  import avalon_mem_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);
  // shift left every cycle, feedback is the parity of the tapped bits
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= SEED;
    else q <= {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/avalon_slave_ram.sv
// avalon_slave_ram: word-addressed Avalon-MM RAM with byte enables, wait states and error flag
module avalon_slave_ram
  import avalon_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter              INIT_FILE   = "",
  parameter bit          RANDOM_WAIT = 1'b0,
  parameter int          WAIT_CYCLES = 2,
  parameter int          MAX_WAIT    = 7,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic              clk,
  input logic              reset,
  avalon_slave_ram_if.slave bus
);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  logic [31:0]   mem [MEM_WORDS];
  state_t        state;
  logic [7:0]    cnt, target, target_now, lfsr;
  logic [31:0]   addr_q, offset;
  logic [IW-1:0] idx;
  logic          req, both, in_range, accept, wr_en;
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr));
  // request decode, address mapping and the accept decision for this cycle
  always_comb begin
    req             = bus.read ^ bus.write;
    both            = bus.read & bus.write;
    target_now      = RANDOM_WAIT ? (lfsr & 8'(MAX_WAIT)) : 8'(WAIT_CYCLES);
    offset          = bus.address - BASE_ADDR;
    idx             = offset[IW+1:2];
    in_range        = (bus.address >= BASE_ADDR) && (offset[31:2] < 30'(MEM_WORDS)) && (offset[1:0] == 2'b0);
    accept          = !reset && (state == IDLE ? (both || (req && target_now == 8'd0)) : (req && cnt == target));
    wr_en           = accept && bus.write && !bus.read && in_range;
    bus.waitrequest = !accept;
    bus.readdata    = (accept && bus.read && !bus.write && in_range) ? mem[idx] : 32'd0;
  end
  // wait-state FSM and sticky protocol/range error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      target  <= 8'd0;
      addr_q  <= 32'd0;
      bus.err <= 1'b0;
    end else begin
      bus.err <= bus.err | (accept && (both || !in_range)) | (state == BUSY && (!req || bus.address != addr_q));
      if (state == IDLE) begin
        if (req && target_now != 8'd0) begin
          state  <= BUSY;
          target <= target_now;
          addr_q <= bus.address;
          cnt    <= 8'd1;
        end
      end else if (!req || cnt == target) state <= IDLE;
      else cnt <= cnt + 8'd1;
    end
  // byte-lane write on the accept edge; contents survive reset
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < AVALON_WORD_BYTES; i++)
        if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
endmodule

// File: tb/tb_avalon_slave_ram.sv
// tb_avalon_slave_ram: fixed/random wait-state RAM instances checked against a behavioural model
module tb_avalon_slave_ram;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam int WORDS = 256;
  logic clk, reset;
  logic        drv_rd [4], drv_wr [4];
  logic [31:0] drv_a [4], drv_wd [4];
  logic [3:0]  drv_be [4];
  logic        obs_wait [4], obs_err [4];
  logic [31:0] obs_rd [4];
  logic [7:0]  ref_lfsr;
  logic [31:0] model [int];
  int n_checks = 0, n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    avalon_slave_ram_if bus ();
    assign bus.read       = drv_rd[g];
    assign bus.write      = drv_wr[g];
    assign bus.address    = drv_a[g];
    assign bus.byteenable = drv_be[g];
    assign bus.writedata  = drv_wd[g];
    assign obs_wait[g]    = bus.waitrequest;
    assign obs_rd[g]      = bus.readdata;
    assign obs_err[g]     = bus.err;
    avalon_slave_ram #(
      .BASE_ADDR(BASE), .MEM_WORDS(WORDS), .RANDOM_WAIT(g == 3),
      .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 4 : 2), .MAX_WAIT(7), .LFSR_SEED(8'hA5)
    ) u_dut (.clk(clk), .reset(reset), .bus(bus));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // polynomial x^8+x^6+x^5+x^4+1 stepped once per clock from the seed
  always @(posedge clk or posedge reset)
    if (reset) ref_lfsr <= 8'hA5;
    else ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits, output logic [7:0] lf);
    bit done = 0;
    drv_rd[d] = !wr; drv_wr[d] = wr; drv_a[d] = a; drv_be[d] = be; drv_wd[d] = wd;
    lf = ref_lfsr;
    waits = 0; rd = 32'd0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (!obs_wait[d]) begin rd = obs_rd[d]; done = 1; end
      else waits++;
    end
    check("accept_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    drv_rd[d] = 1'b0; drv_wr[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic [7:0] lf;
    logic [3:0] be;
    int w, ai;
    for (int i = 0; i < 4; i++) begin
      drv_rd[i] = 0; drv_wr[i] = 0; drv_a[i] = BASE; drv_be[i] = 4'hF; drv_wd[i] = 0;
    end
    reset = 1'b1;
    drv_rd[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait0", 32'(obs_wait[0]), 32'd1);
    check("rst_rdata0", obs_rd[0], 32'd0);
    check("rst_wait2", 32'(obs_wait[2]), 32'd1);
    drv_rd[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_err0", 32'(obs_err[0]), 32'd0);
    check("rst_err3", 32'(obs_err[3]), 32'd0);
    // zero wait states
    access(0, 1, BASE, 4'hF, 32'hDEADBEEF, rd, w, lf);
    check("w0_wr_wait", w, 0);
    access(0, 0, BASE, 4'hF, 0, rd, w, lf);
    check("w0_rd_wait", w, 0);
    check("w0_rd_data", rd, 32'hDEADBEEF);
    // byte lanes
    access(0, 1, BASE + 8, 4'hF, 32'h11223344, rd, w, lf);
    access(0, 1, BASE + 8, 4'b0101, 32'hAABBCCDD, rd, w, lf);
    access(0, 0, BASE + 8, 4'hF, 0, rd, w, lf);
    check("lanes_data", rd, 32'h11BB33DD);
    check("w0_err_clean", 32'(obs_err[0]), 32'd0);
    // three wait states
    access(1, 1, BASE + 4, 4'hF, 32'hCAFEF00D, rd, w, lf);
    check("w3_wr_wait", w, 3);
    access(1, 0, BASE + 4, 4'hF, 0, rd, w, lf);
    check("w3_rd_wait", w, 3);
    check("w3_rd_data", rd, 32'hCAFEF00D);
    // abort a pending read after two wait cycles
    access(2, 1, BASE + 12, 4'hF, 32'h12345678, rd, w, lf);
    check("w4_wr_wait", w, 4);
    check("w4_err_clean", 32'(obs_err[2]), 32'd0);
    drv_rd[2] = 1'b1; drv_a[2] = BASE + 12;
    @(negedge clk);
    check("abort_wait1", 32'(obs_wait[2]), 32'd1);
    @(negedge clk);
    check("abort_wait2", 32'(obs_wait[2]), 32'd1);
    @(posedge clk); #1 drv_rd[2] = 1'b0;
    @(posedge clk); #1;
    check("abort_err", 32'(obs_err[2]), 32'd1);
    access(2, 0, BASE + 12, 4'hF, 0, rd, w, lf);
    check("after_abort_wait", w, 4);
    check("after_abort_data", rd, 32'h12345678);
    // out-of-range and misaligned accesses
    access(0, 0, BASE + 4 * WORDS, 4'hF, 0, rd, w, lf);
    check("range_rd_wait", w, 0);
    check("range_rd_data", rd, 32'd0);
    check("range_err", 32'(obs_err[0]), 32'd1);
    access(0, 1, BASE + 4 * WORDS, 4'hF, 32'h55555555, rd, w, lf);
    access(0, 0, BASE, 4'hF, 0, rd, w, lf);
    check("range_wr_dropped", rd, 32'hDEADBEEF);
    access(0, 0, BASE + 2, 4'hF, 0, rd, w, lf);
    check("misalign_data", rd, 32'd0);
    access(0, 0, BASE - 4, 4'hF, 0, rd, w, lf);
    check("below_base_data", rd, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("range_err_sticky", 32'(obs_err[0]), 32'd1);
    // simultaneous read and write
    check("w3_err_clean", 32'(obs_err[1]), 32'd0);
    drv_rd[1] = 1'b1; drv_wr[1] = 1'b1; drv_a[1] = BASE + 4; drv_wd[1] = 32'h0; drv_be[1] = 4'hF;
    @(negedge clk);
    check("both_wait", 32'(obs_wait[1]), 32'd0);
    check("both_rdata", obs_rd[1], 32'd0);
    @(posedge clk); #1 drv_rd[1] = 1'b0; drv_wr[1] = 1'b0;
    check("both_err", 32'(obs_err[1]), 32'd1);
    access(1, 0, BASE + 4, 4'hF, 0, rd, w, lf);
    check("both_no_write", rd, 32'hCAFEF00D);
    // random wait states against the reference model
    for (int t = 0; t < 1000; t++) begin
      ai = $urandom_range(0, 63);
      if (!model.exists(ai) || $urandom_range(0, 1) == 1) begin
        be = model.exists(ai) ? 4'($urandom) : 4'hF;
        wd = $urandom;
        if (!model.exists(ai)) model[ai] = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) model[ai][8*i +: 8] = wd[8*i +: 8];
        access(3, 1, BASE + 32'(ai) * 4, be, wd, rd, w, lf);
      end else begin
        access(3, 0, BASE + 32'(ai) * 4, 4'hF, 0, rd, w, lf);
        check("rnd_data", rd, model[ai]);
      end
      check("rnd_wait", w, 32'(lf & 8'h07));
    end
    check("rnd_err", 32'(obs_err[3]), 32'd0);
    // reset during a pending write: the write must never land
    drv_wr[2] = 1'b1; drv_a[2] = BASE + 12; drv_be[2] = 4'hF; drv_wd[2] = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst_wait", 32'(obs_wait[2]), 32'd1);
    @(posedge clk); #1;
    drv_wr[2] = 1'b0;
    reset = 1'b0;
    check("midrst_err", 32'(obs_err[2]), 32'd0);
    access(2, 0, BASE + 12, 4'hF, 0, rd, w, lf);
    check("midrst_wait4", w, 4);
    check("midrst_data", rd, 32'h12345678);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
